// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, arbiter states and the abort word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2,
        RETRY = 2'd3
    } arb_state_t;

    localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating wait counter for the arbiter; expired_o holds once TIMEOUT_CYCLES is reached.
module arb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and data load/store onto one RAM port, data first.
// Optional abort-on-timeout is built when MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_WORD       = ERR_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    arb_state_t  state_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic        wr_q;
    logic        is_data_q;
    logic        ren_q;
    logic        wen_q;

    logic        serving;
    logic        access_hit;
    logic        timeout_hit;
    logic        done;
    logic [31:0] resp_word;

    assign serving    = (state_q == DSERV) || (state_q == ISERV);
    assign access_hit = serving && (ramstate == ACCESS);

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic expired;

    // The count survives RETRY so a flaky RAM cannot extend the deadline.
    arb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .clear_i  (state_q == IDLE),
        .enable_i ((state_q == RETRY) || (serving && (ramstate != ACCESS))),
        .expired_o(expired)
    );

    assign timeout_hit = serving && !access_hit && expired;
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES > 0);
    assign timeout_hit = 1'b0;
`endif

    assign done = access_hit || timeout_hit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            store_q   <= '0;
            wr_q      <= 1'b0;
            is_data_q <= 1'b0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dREN || dWEN) begin
                        state_q   <= DSERV;
                        addr_q    <= daddr;
                        store_q   <= dstore;
                        wr_q      <= dWEN;
                        is_data_q <= 1'b1;
                        ren_q     <= !dWEN;
                        wen_q     <= dWEN;
                    end else if (iREN) begin
                        state_q   <= ISERV;
                        addr_q    <= iaddr;
                        wr_q      <= 1'b0;
                        is_data_q <= 1'b0;
                        ren_q     <= 1'b1;
                        wen_q     <= 1'b0;
                    end
                end
                DSERV, ISERV: begin
                    if (done) begin
                        state_q <= IDLE;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                    end else if (ramstate == ERROR) begin
                        state_q <= RETRY;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                    end
                end
                RETRY: begin
                    state_q <= is_data_q ? DSERV : ISERV;
                    ren_q   <= !(is_data_q && wr_q);
                    wen_q   <= is_data_q && wr_q;
                end
                default: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    // Completion data is a same-cycle pass-through of ramload; writes return zero.
    assign resp_word = timeout_hit ? ERR_WORD : (wr_q ? 32'h0 : ramload);

    assign dwait   = !(done && is_data_q);
    assign iwait   = !(done && !is_data_q);
    assign dload   = (done && is_data_q)  ? resp_word : 32'h0;
    assign iload   = (done && !is_data_q) ? resp_word : 32'h0;
    assign arb_err = timeout_hit;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic
// compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 4;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        arb_err;

    mem_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ERR_WORD      (32'hBAD1BAD1)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .arb_err (arb_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the outstanding transaction (none while m_busy is 0)
    bit          m_busy  = 1'b0;
    bit          m_data  = 1'b0;
    bit          m_wr    = 1'b0;
    bit          m_retry = 1'b0;
    int          m_age   = 0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_store = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock cycle: predict and compare this cycle's outputs, then advance the model.
    task automatic step();
        logic        exp_iw, exp_dw, exp_ren, exp_wen, exp_err, done;
        logic [31:0] exp_load;
        @(negedge CLK);
        #1;
        exp_iw = 1'b1; exp_dw = 1'b1; exp_ren = 1'b0; exp_wen = 1'b0;
        exp_err = 1'b0; done = 1'b0; exp_load = 32'h0;
        if (!nRST) begin
            m_busy = 1'b0;
            check_eq("rst_ramaddr", ramaddr, 32'h0);
            check_eq("rst_ramstore", ramstore, 32'h0);
            check_eq("rst_iload", iload, 32'h0);
            check_eq("rst_dload", dload, 32'h0);
        end else if (m_busy && !m_retry) begin
            exp_ren = !(m_data && m_wr);
            exp_wen = m_data && m_wr;
            if (ramstate == ACCESS) begin
                done = 1'b1;
                exp_load = m_wr ? 32'h0 : ramload;
            end else if (TO_EN && m_age >= TO) begin
                done = 1'b1;
                exp_err = 1'b1;
                exp_load = 32'hBAD1BAD1;
            end
            if (done) begin
                if (m_data) exp_dw = 1'b0;
                else        exp_iw = 1'b0;
                $display("txn %s %s addr=%h data=%h%s", m_data ? "D" : "I",
                         m_wr ? "wr" : "rd", m_addr, m_wr ? m_store : exp_load,
                         exp_err ? " aborted" : "");
            end
        end
        check_eq("iwait", 32'(iwait), 32'(exp_iw));
        check_eq("dwait", 32'(dwait), 32'(exp_dw));
        check_eq("ramREN", 32'(ramREN), 32'(exp_ren));
        check_eq("ramWEN", 32'(ramWEN), 32'(exp_wen));
        check_eq("arb_err", 32'(arb_err), 32'(exp_err));
        if (exp_ren || exp_wen) check_eq("ramaddr", ramaddr, m_addr);
        if (exp_wen)            check_eq("ramstore", ramstore, m_store);
        if (!exp_iw)            check_eq("iload", iload, exp_load);
        if (!exp_dw)            check_eq("dload", dload, exp_load);

        if (nRST) begin
            if (!m_busy) begin
                if (dREN || dWEN) begin
                    m_busy = 1'b1; m_data = 1'b1; m_wr = dWEN;
                    m_addr = daddr; m_store = dstore; m_retry = 1'b0; m_age = 0;
                end else if (iREN) begin
                    m_busy = 1'b1; m_data = 1'b0; m_wr = 1'b0;
                    m_addr = iaddr; m_retry = 1'b0; m_age = 0;
                end
            end else if (m_retry) begin
                m_retry = 1'b0;
                m_age++;
            end else if (done) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
                if (ramstate == ERROR) m_retry = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic i_r, input logic [31:0] ia, input logic d_r, input logic d_w,
                         input logic [31:0] da, input logic [31:0] ds,
                         input logic [1:0] rs, input logic [31:0] rl);
        iREN = i_r; iaddr = ia; dREN = d_r; dWEN = d_w;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
        step();
    endtask

    initial begin
        int r;
        nRST = 1'b1;
        iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; ramstate = FREE; ramload = 32'h0;
        #1 nRST = 1'b0;

        // Reset held with a pending fetch, then fetch with two BUSY cycles
        repeat (3) drive(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h0);
        nRST = 1'b1;
        drive(1, 32'h40, 0, 0, 0, 0, FREE, 32'h0);
        drive(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h0);
        drive(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h0);
        drive(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C220004);
        drive(0, 32'h40, 0, 0, 0, 0, FREE, 32'h0);

        // Simultaneous fetch and store: store first, mandatory idle, then fetch
        drive(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, FREE, 32'h0);
        drive(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, ACCESS, 32'h55);
        drive(1, 32'h44, 0, 0, 32'h80, 32'h0, FREE, 32'h0);
        drive(1, 32'h44, 0, 0, 0, 0, BUSY, 32'h0);
        drive(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'hCAFE0001);
        drive(0, 32'h0, 0, 0, 0, 0, FREE, 32'h0);

        // ERROR -> one RETRY cycle -> reissue of the same load
        drive(0, 0, 1, 0, 32'h100, 0, FREE, 32'h0);
        drive(0, 0, 1, 0, 32'h100, 0, ERROR, 32'h0);
        drive(0, 0, 1, 0, 32'h100, 0, ACCESS, 32'h0);
        drive(0, 0, 1, 0, 32'h100, 0, BUSY, 32'h0);
        drive(0, 0, 1, 0, 32'h100, 0, ACCESS, 32'h12345678);
        drive(0, 0, 0, 0, 32'h0, 0, FREE, 32'h0);

        // Address change mid-transaction is ignored
        drive(0, 0, 1, 0, 32'h100, 0, FREE, 32'h0);
        drive(0, 0, 1, 0, 32'h100, 0, BUSY, 32'h0);
        drive(0, 0, 1, 0, 32'h200, 0, BUSY, 32'h0);
        drive(0, 0, 1, 0, 32'h200, 0, ACCESS, 32'h0BADF00D);
        drive(0, 0, 0, 0, 32'h0, 0, FREE, 32'h0);

`ifdef MEM_ARBITER_TIMEOUT_EN
        // RAM stuck BUSY: abort after TO cycles of strobe
        drive(0, 0, 1, 0, 32'h300, 0, FREE, 32'h0);
        repeat (TO + 1) drive(0, 0, 1, 0, 32'h300, 0, BUSY, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, BUSY, 32'h0);
`endif

        for (int c = 0; c < 1500; c++) begin
            iREN  = ($urandom_range(0, 9) < 6);
            iaddr = $urandom;
            r = $urandom_range(0, 9);
            dREN  = (r < 3) || (r == 5);
            dWEN  = (r == 3) || (r == 4) || (r == 5);
            daddr = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 19);
            if (r < 8)       ramstate = ACCESS;
            else if (r < 14) ramstate = BUSY;
            else if (r < 17) ramstate = FREE;
            else             ramstate = ERROR;
            if ($urandom_range(0, 199) == 0) nRST = 1'b0;
            step();
            nRST = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the request unit; serialises instruction-fetch and data load/store requests onto the single RAM port.
- Latches the winning request and holds it on the RAM bus until the RAM reports completion.
- Returns the load data and a per-requester wait/ready indication back upstream.
- Data requests have priority over instruction fetch.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles a transaction may wait for ACCESS before it is aborted (used only with the optional feature).
- ERR_WORD, 32'hBAD1BAD1: load value returned on an aborted transaction (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  high while the instruction request is not yet complete.
- iload  out  32  instruction word; valid when iREN && !iwait.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN && dWEN together is illegal, and dWEN wins.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  high while the data request is not yet complete.
- dload  out  32  data read word; valid when dREN && !dwait.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- arb_err  out  1  one-cycle pulse on abort (optional feature only; tied 0 otherwise).

Behaviour:
- State register arb_state_t: IDLE, DSERV, ISERV, RETRY.
- Reset (async, nRST low):
  - state=IDLE; ramREN=ramWEN=0; ramaddr=ramstore=0; latched regs=0.
  - iwait=dwait=1; iload=dload=0; arb_err=0.
  - Reset mid-transaction drops the transaction; no completion is reported.
- IDLE: ram strobes 0; iwait=dwait=1.
  - dREN|dWEN → latch daddr, dstore and op (read or write), go to DSERV.
  - Otherwise iREN → latch iaddr, go to ISERV.
  - Both pending at once → DSERV (data priority).
- DSERV / ISERV:
  - Drive ramaddr/ramstore from the latched regs, and ramREN/ramWEN from the latched op.
  - Upstream address/data changes are ignored until completion.
  - ramstate==ACCESS: in the same cycle the matching wait=0 and load=ramload (combinational pass-through). Next state IDLE.
  - ramstate==ERROR: go to RETRY; wait stays 1.
  - ramstate FREE or BUSY: hold state.
- RETRY: strobes 0 for exactly one cycle, then return to the state that entered it with the latched request unchanged.
- Latency: request seen in IDLE at cycle N → RAM strobes asserted at N+1 → earliest completion at N+1 (2 cycles request-to-done).
  - Back-to-back requests: the IDLE cycle between transactions is mandatory.
- Requester drops its request mid-transaction: the RAM transaction still completes; the completion is reported via wait=0 but ignored upstream.
- Only one of iwait/dwait is ever 0 in any cycle.
- Write completion: dwait=0; dload is don't-care and driven to 0.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter (clog2(TIMEOUT_CYCLES)+1 bits) clears on entry to DSERV/ISERV and increments each cycle without ACCESS.
  - On reaching TIMEOUT_CYCLES: abort. The matching wait=0 with load=ERR_WORD, arb_err=1 for that cycle, then IDLE.
  - The counter also runs through RETRY cycles.
- Undefined: no counter; the arbiter waits indefinitely; arb_err is tied 0.

Decomposition:
- ramstate_t and word_t come from cpu_types_pkg.
- Add arb_state_t and the ERR_WORD default constant to cpu_types_pkg.
- One natural sub-module: arb_timeout_ctr (clear/enable/expired), instantiated only under MEM_ARBITER_TIMEOUT_EN.

Test Plan:
1. Reset with iREN=1 held low-reset 3 cycles → all outputs at reset values; first cycle after release IDLE, ramREN=0; next cycle ramREN=1, ramaddr=iaddr.
2. iREN=1, iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0x8C220004 → iwait=0 and iload=0x8C220004 exactly on the ACCESS cycle; IDLE next.
3. iREN=1 and dWEN=1 (daddr=0x80, dstore=0xDEADBEEF) in the same cycle → ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF first. After ACCESS, one IDLE cycle, then ramREN=1, ramaddr=iaddr.
4. dREN=1, daddr=0x100; ramstate ERROR one cycle → one RETRY cycle with strobes 0, then ramREN=1, ramaddr=0x100 again. ACCESS with ramload=0x12345678 → dload=0x12345678.
5. dREN=1, change daddr 0x100→0x200 mid-transaction → ramaddr stays 0x100 until completion.
6. With MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, ramstate stuck BUSY → 4 cycles after strobe assertion: dwait=0, dload=0xBAD1BAD1, arb_err=1 for one cycle, then IDLE.
